floo_vc_input_buffer: RTL

Input buffer for one port of the virtual-channel router. Incoming flits are written into per-VC FIFOs selected by hdr.vc_id, and the head of every VC is exposed to the route/switch-allocation stages. The block returns credits upstream with one registered cycle and tracks packet boundaries per VC, so downstream logic knows when a head flit needs route computation. It detects and reports credit-protocol violations.

---
 rtl/floo_pkg.sv | 35 +++
 rtl/floo_vc_fifo.sv | 81 ++++++++
 rtl/floo_vc_input_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/floo_pkg.sv
// Shared types for the virtual-channel input buffer: default header/flit
// layout, a VC index type and a one-hot to binary encoder.
package floo_pkg;

   localparam int unsigned MaxVC        = 16;
   localparam int unsigned VcIdWidth    = 4;
   localparam int unsigned PayloadWidth = 16;

   typedef logic [VcIdWidth-1:0] vc_id_t;

   typedef struct packed {
      vc_id_t vc_id;
      logic   last;
   } hdr_t;

   typedef struct packed {
      hdr_t                    hdr;
      logic [PayloadWidth-1:0] payload;
   } flit_t;

   // OR of the indices of all set bits; exact for one-hot or all-zero input.
   function automatic vc_id_t onehot2bin(input logic [MaxVC-1:0] oh);
      vc_id_t idx;
      idx = 4'd0;
      for (int i = 0; i < MaxVC; i++) begin
         if (oh[i]) begin
            idx = idx | vc_id_t'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/floo_vc_fifo.sv
// Single-VC flit FIFO. Registered head (no fall-through), pointer wrap by
// explicit compare so any depth works, and push at full is accepted when a
// pop happens in the same cycle.
module floo_vc_fifo
   import floo_pkg::*;
#(
   parameter type         flit_t   = floo_pkg::flit_t,
   parameter int unsigned Depth    = 3,
   parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                push_i,
   input  logic                pop_i,
   input  flit_t               data_i,
   output logic                full_o,
   output logic                empty_o,
   output logic [CntWidth-1:0] usage_o,
   output flit_t               head_o
);

   localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
   localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

   flit_t               mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntWidth-1:0] usage_q, usage_d;
   logic                do_push_s, do_pop_s;

   assign empty_o   = (usage_q == {CntWidth{1'b0}});
   assign full_o    = (usage_q == DepthCnt);
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign usage_o   = usage_q;
   assign head_o    = empty_o ? flit_t'(0) : mem_q[rd_ptr_q];

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usage_d  = usage_q;
      if (do_push_s) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? {PtrWidth{1'b0}} : wr_ptr_q + PtrWidth'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? {PtrWidth{1'b0}} : rd_ptr_q + PtrWidth'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   usage_d = usage_q + CntWidth'(1);
         2'b01:   usage_d = usage_q - CntWidth'(1);
         default: usage_d = usage_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {PtrWidth{1'b0}};
         rd_ptr_q <= {PtrWidth{1'b0}};
         usage_q  <= {CntWidth{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usage_q  <= usage_d;
      end
   end

   // Flit storage; contents are only observed while the FIFO is non-empty.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/floo_vc_input_buffer.sv
// Router input port buffer: per-VC FIFOs, registered credit return,
// per-VC packet-boundary flags and sticky credit-protocol error capture.
module floo_vc_input_buffer
   import floo_pkg::*;
#(
   parameter type         flit_t     = floo_pkg::flit_t,
   parameter type         hdr_t      = floo_pkg::hdr_t,
   parameter int unsigned NumVC      = 4,
   parameter int unsigned NumVCWidth = (NumVC > 1) ? $clog2(NumVC) : 1,
   parameter int unsigned VCDepth    = 3,
   parameter int unsigned CntWidth   = $clog2(VCDepth + 1)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               data_v_i,
   input  flit_t                              data_i,
   output logic                               credit_v_o,
   output logic [NumVCWidth-1:0]              credit_id_o,
   output logic [NumVC-1:0]                   vc_head_v_o,
   output flit_t [NumVC-1:0]                  vc_head_o,
   output logic [NumVC-1:0]                   vc_head_first_o,
   input  logic [NumVC-1:0]                   vc_pop_i,
   output logic [NumVC-1:0][CntWidth-1:0]     vc_usage_o,
   output logic                               overflow_o,
   output logic                               underflow_o,
   output logic [NumVCWidth-1:0]              err_vc_id_o
);

   logic [NumVCWidth-1:0] in_vc_s;
   logic                  in_vc_ok_s;
   logic [NumVC-1:0]      push_s, pop_ok_s, full_s, empty_s, pop_low_s;
   logic                  pop_onehot_s, pop_multi_s, pop_empty_s;
   logic                  ovf_ev_s, unf_ev_s;

   logic                  credit_v_q, credit_v_d;
   logic [NumVCWidth-1:0] credit_id_q, credit_id_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic [NumVCWidth-1:0] err_vc_q, err_vc_d;
   logic [NumVC-1:0]      first_q, first_d;

   // Upper vc_id bits are ignored; a truncated id beyond NumVC is still illegal.
   assign in_vc_s    = NumVCWidth'(data_i.hdr.vc_id);
   assign in_vc_ok_s = (32'(in_vc_s) < NumVC);

   assign pop_onehot_s = (vc_pop_i != {NumVC{1'b0}}) &&
                         ((vc_pop_i & (vc_pop_i - NumVC'(1))) == {NumVC{1'b0}});
   assign pop_multi_s  = (vc_pop_i != {NumVC{1'b0}}) & ~pop_onehot_s;
   assign pop_ok_s     = pop_onehot_s ? (vc_pop_i & ~empty_s) : {NumVC{1'b0}};
   assign pop_empty_s  = pop_onehot_s & (|(vc_pop_i & empty_s));
   assign pop_low_s    = vc_pop_i & (~vc_pop_i + NumVC'(1));

   // A push into a full VC survives only if that VC is popped in the same cycle.
   assign ovf_ev_s = data_v_i & (~in_vc_ok_s | (|(push_s & full_s & ~pop_ok_s)));
   assign unf_ev_s = pop_multi_s | pop_empty_s;

   for (genvar v = 0; v < NumVC; v++) begin : gen_vc
      assign push_s[v] = data_v_i & in_vc_ok_s & (in_vc_s == NumVCWidth'(v));

      floo_vc_fifo #(
         .flit_t   (flit_t),
         .Depth    (VCDepth),
         .CntWidth (CntWidth)
      ) i_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .push_i  (push_s[v]),
         .pop_i   (pop_ok_s[v]),
         .data_i  (data_i),
         .full_o  (full_s[v]),
         .empty_o (empty_s[v]),
         .usage_o (vc_usage_o[v]),
         .head_o  (vc_head_o[v])
      );
   end

   assign vc_head_v_o     = ~empty_s;
   // Idle VCs report "first" so a newly arriving flit is treated as a head.
   assign vc_head_first_o = first_q | empty_s;
   assign credit_v_o      = credit_v_q;
   assign credit_id_o     = credit_id_q;
   assign overflow_o      = ovf_q;
   assign underflow_o     = unf_q;
   assign err_vc_id_o     = err_vc_q;

   // Next credit, error and first-flag state.
   always_comb begin
      credit_v_d  = |pop_ok_s;
      credit_id_d = NumVCWidth'(onehot2bin(MaxVC'(pop_ok_s)));
      ovf_d       = ovf_q | ovf_ev_s;
      unf_d       = unf_q | unf_ev_s;
      err_vc_d    = err_vc_q;
      first_d     = first_q;
      if (!(ovf_q | unf_q) && (ovf_ev_s | unf_ev_s)) begin
         if (ovf_ev_s) begin
            err_vc_d = in_vc_s;
         end else begin
            err_vc_d = NumVCWidth'(onehot2bin(MaxVC'(pop_low_s)));
         end
      end else begin
         err_vc_d = err_vc_q;
      end
      for (int v = 0; v < NumVC; v++) begin
         if (pop_ok_s[v]) begin
            first_d[v] = vc_head_o[v].hdr.last;
         end else begin
            first_d[v] = first_q[v];
         end
      end
   end

   // Credit, sticky error and packet-boundary registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credit_v_q  <= 1'b0;
         credit_id_q <= {NumVCWidth{1'b0}};
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         err_vc_q    <= {NumVCWidth{1'b0}};
         first_q     <= {NumVC{1'b1}};
      end else begin
         credit_v_q  <= credit_v_d;
         credit_id_q <= credit_id_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         err_vc_q    <= err_vc_d;
         first_q     <= first_d;
      end
   end

endmodule
